fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end that sits between the 64-bit PC register and instruction memory.
- Consumes the PC register output, issues fetch requests to instruction memory, and buffers the returned 32-bit instructions for decode.
- Drives the PC register input with the next PC. The PC register has no enable, so this block holds the PC on stall.

Parameters:
- DEPTH, 2, instruction buffer entries (power of 2, >=2).
- XLEN, 64, PC/address width.
- ILEN, 32, instruction width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc_in  in  XLEN  current PC (PC register OUT).
- next_pc  out  XLEN  next PC (PC register IN); combinational.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  XLEN  fetch address.
- imem_resp_valid  in  1  response data valid (1-cycle pulse).
- imem_resp_data  in  ILEN  fetched instruction.
- redirect_valid  in  1  branch/jump redirect.
- redirect_pc  in  XLEN  redirect target.
- inst_valid  out  1  buffer head valid.
- inst_ready  in  1  decode accepts head.
- inst_data  out  ILEN  head instruction.
- inst_pc  out  XLEN  PC of head instruction.

Behaviour:
- Reset (rst=0, async), all registered state cleared:
  - state=IDLE; count=0; rd/wr pointers=0; req_pc_q=0.
  - inst_valid=0, inst_data=0, inst_pc=0.
  - imem_req_valid=0.
  - next_pc=pc_in (hold).
- FSM, at most one outstanding request:
  - IDLE: no request in flight.
  - WAIT: request accepted, response pending.
  - DROP: response pending but to be discarded.
- Request rule:
  - imem_req_valid = (state==IDLE) && (count<DEPTH) && !redirect_valid.
  - imem_addr = {pc_in[XLEN-1:2],2'b00}.
  - Handshake = imem_req_valid && imem_req_ready. It latches req_pc_q<=imem_addr and moves IDLE->WAIT.
- next_pc priority:
  - redirect_valid: redirect_pc.
  - else handshake: pc_in+4 (wraps mod 2^XLEN).
  - else: pc_in.
- Response handling:
  - WAIT + imem_resp_valid: write {imem_resp_data, req_pc_q} at wr pointer, count+1, ->IDLE. The slot is guaranteed free because the request was issued only when count<DEPTH.
  - DROP + imem_resp_valid: data discarded, ->IDLE.
  - imem_resp_valid in IDLE is ignored.
- Issue latency: a new request may issue in the cycle after a response returns. Back-to-back throughput is 1 instr / (memory latency+1) cycles.
- Output side:
  - inst_valid = (count!=0).
  - inst_data/inst_pc come from the rd pointer entry.
  - Pop on inst_valid && inst_ready: rd pointer +1 mod DEPTH, count-1.
  - Simultaneous push and pop leaves count unchanged.
- Redirect (redirect_valid=1), effective at the next edge:
  - Buffer flushed: count=0, pointers=0.
  - A pop in the same cycle still counts as delivered.
  - WAIT->DROP.
  - A response arriving in the same cycle is discarded and the FSM goes to IDLE instead of DROP.
  - DROP stays DROP.
  - No request issues during the redirect cycle.
- Reset mid-request: state returns to IDLE; any later response is ignored.
- Pointers wrap mod DEPTH. count ranges 0..DEPTH.

Test Plan:
1. Reset, then rst=1 with pc_in=64'h0, req_ready=1, and a 2-cycle response of 32'h00000013 -> next_pc=64'h4 on the handshake cycle, inst_valid=1 with inst_pc=64'h0 and inst_data=32'h00000013 the cycle after the response.
2. inst_ready=0 with continuous fetch from pc 64'h100 -> exactly 2 entries buffered (pc 64'h100, 64'h104); imem_req_valid then held 0 and next_pc==pc_in==64'h108 until a pop.
3. Redirect to 64'hAAAAAAAABBBBBBB8 while in WAIT -> buffer empty the next cycle; the pending response is dropped; the next request has imem_addr=64'hAAAAAAAABBBBBBB8.
4. Redirect and imem_resp_valid in the same cycle -> response discarded, state IDLE, next request issued the following cycle at the redirect target.
5. pc_in=64'hFFFFFFFFFFFFFFFC with handshake -> next_pc=64'h0 (wrap). pc_in=64'hAAAAAAAAFFFFFFFF -> imem_addr=64'hAAAAAAAAFFFFFFFC.
6. Assert rst=0 while in WAIT, then a response arrives after release -> inst_valid stays 0 and the response is ignored.

Source files
------------

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Bundle of every non-clock, non-reset signal of the
//               instruction-fetch front end: the PC register loop, the
//               instruction-memory request/response channel, the branch
//               redirect input and the decode-side instruction stream.
//
// Signals (direction seen from the fetch unit, i.e. the master modport):
//   pc_in            in   XLEN  current PC (PC register output)
//   next_pc          out  XLEN  next PC (PC register input), combinational
//   imem_req_valid   out  1     fetch request valid
//   imem_req_ready   in   1     memory accepts the request
//   imem_addr        out  XLEN  word-aligned fetch address
//   imem_resp_valid  in   1     response data valid (single-cycle pulse)
//   imem_resp_data   in   ILEN  fetched instruction
//   redirect_valid   in   1     branch/jump redirect
//   redirect_pc      in   XLEN  redirect target
//   inst_valid       out  1     buffer head valid
//   inst_ready       in   1     decode accepts the head
//   inst_data        out  ILEN  head instruction
//   inst_pc          out  XLEN  PC of the head instruction
//
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);

  // PC register loop
  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] next_pc;

  // Instruction memory request channel
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;

  // Instruction memory response channel
  logic            imem_resp_valid;
  logic [ILEN-1:0] imem_resp_data;

  // Control-flow redirect
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  // Decode-side instruction stream
  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;

  // The fetch unit itself
  modport master (
    input  pc_in,
    output next_pc,
    output imem_req_valid,
    input  imem_req_ready,
    output imem_addr,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc
  );

  // The surroundings: PC register, instruction memory, branch unit, decode
  modport slave (
    output pc_in,
    input  next_pc,
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_addr,
    output imem_resp_valid,
    output imem_resp_data,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc
  );

endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch front end between the PC register and the
//               instruction memory. Issues at most one outstanding fetch,
//               buffers returned instructions (with their PCs) in a small
//               circular buffer for decode, and drives the PC register input.
//               The PC register has no enable, so the PC is held here by
//               feeding pc_in straight back whenever no fetch is accepted.
//
// Ports:
//   clk   in  1     clock, rising edge
//   rst   in  1     asynchronous, active-low reset
//   bus   --  fetch_unit_if.master (PC loop, imem channel, redirect, decode)
//
// Parameters:
//   DEPTH  instruction buffer entries (power of 2, >= 2)
//   XLEN   PC / address width
//   ILEN   instruction width
//
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 64,
  parameter int ILEN  = 32
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int PTR_W = $clog2(DEPTH);
  // One extra bit so the count can represent a completely full buffer.
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(4);
  // Clears the two byte-offset bits to give a word-aligned fetch address.
  localparam logic [XLEN-1:0]  ADDR_MASK = ~XLEN'(3);

  // --------------------------------------------------------------------------
  // Request FSM encoding
  //   IDLE : nothing in flight, may issue
  //   WAIT : request accepted, its response will be buffered
  //   DROP : request accepted, its response is stale (redirect hit) and
  //          will be thrown away
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t            state_q,  state_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;

  // Instruction buffer storage: instruction word and the PC it came from
  logic [ILEN-1:0]   data_q [DEPTH];
  logic [XLEN-1:0]   pc_q   [DEPTH];

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic [XLEN-1:0]   fetch_addr;
  logic              req_valid;
  logic              handshake;
  logic              buf_nonempty;
  logic              push;
  logic              pop;

  always_comb begin
    fetch_addr   = bus.pc_in & ADDR_MASK;
    buf_nonempty = (count_q != '0);

    // A request is only offered when a buffer slot is guaranteed for its
    // response; that is what lets a WAIT response be written unconditionally.
    // Holding rst low also suppresses the request so the PC is held.
    req_valid = rst
             && (state_q == ST_IDLE)
             && (count_q < FULL_CNT)
             && !bus.redirect_valid;
    handshake = req_valid && bus.imem_req_ready;

    // A response that coincides with a redirect belongs to the old path.
    push = (state_q == ST_WAIT) && bus.imem_resp_valid && !bus.redirect_valid;
    pop  = buf_nonempty && bus.inst_ready;
  end

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A response always closes the transaction, even when a redirect in
        // the same cycle causes it to be discarded; only a redirect with the
        // response still outstanding needs the DROP state.
        if (bus.imem_resp_valid) begin
          state_d = ST_IDLE;
        end else if (bus.redirect_valid) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (bus.imem_resp_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Buffer bookkeeping and request PC
  // --------------------------------------------------------------------------
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    req_pc_d = req_pc_q;

    if (handshake) begin
      req_pc_d = fetch_addr;
    end

    if (bus.redirect_valid) begin
      // Flush. A pop this cycle has already been seen by decode, so nothing
      // further is needed to account for it.
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      req_pc_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      req_pc_q <= req_pc_d;
      if (push) begin
        data_q[wr_ptr_q] <= bus.imem_resp_data;
        pc_q[wr_ptr_q]   <= req_pc_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Redirect wins over sequential advance; otherwise the PC only moves when
  // memory actually accepted the fetch, which is what holds it on stall.
  assign bus.next_pc        = bus.redirect_valid ? bus.redirect_pc :
                              handshake          ? (bus.pc_in + PC_STEP) :
                                                   bus.pc_in;
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = fetch_addr;

  assign bus.inst_valid     = buf_nonempty;
  assign bus.inst_data      = data_q[rd_ptr_q];
  assign bus.inst_pc        = pc_q[rd_ptr_q];

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. The bench plays the PC
//               register, the instruction memory (variable latency) and the
//               decode stage. A queue-based model predicts every output each
//               cycle; directed sequences pin the model with literal values,
//               then a long randomized run follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int DEPTH = 2;
  localparam int XLEN  = 64;
  localparam int ILEN  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

  fetch_unit #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN),
    .ILEN  (ILEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus controls
  bit          rand_mode;
  bit          drv_rst;
  bit          drv_redirect;
  logic [63:0] drv_redirect_pc;
  bit          drv_ready;
  bit          drv_inst_ready;
  logic [31:0] drv_resp_data;
  int          lat_min, lat_max;
  logic [63:0] pc_reg;      // PC register held by the bench
  int          resp_cd;     // cycles until memory answers (0 = idle)

  // Reference model: FIFO contents plus the fate of the request in flight
  logic [63:0] mq_pc[$];
  logic [31:0] mq_data[$];
  int          pend;        // 0 nothing in flight, 1 keep response, 2 discard
  logic [63:0] m_req_pc;
  bit          m_fresh;     // storage still all-zero since reset

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq_pc.delete();
    mq_data.delete();
    pend     = 0;
    m_req_pc = '0;
    m_fresh  = 1'b1;
  endtask

  // One clock cycle: drive inputs after the rising edge, compare against the
  // model at the falling edge, then advance the model.
  task automatic tick();
    logic [63:0] e_next, e_addr;
    bit          e_req, e_valid, hs, resp;
    @(posedge clk);
    #1;
    if (rand_mode) begin
      drv_rst         = ($urandom_range(0, 199) != 0);
      drv_redirect    = drv_rst && ($urandom_range(0, 9) == 0);
      drv_redirect_pc = {$urandom(), $urandom()};
      drv_ready       = ($urandom_range(0, 9) < 7);
      drv_inst_ready  = ($urandom_range(0, 1) == 1);
      drv_resp_data   = $urandom();
    end
    resp = 1'b0;
    if (resp_cd > 0) begin
      resp_cd--;
      resp = (resp_cd == 0);
    end else if (rand_mode && $urandom_range(0, 29) == 0) begin
      resp = 1'b1;   // stray response with nothing in flight
    end
    rst                 = drv_rst;
    bus.pc_in           = pc_reg;
    bus.imem_req_ready  = drv_ready;
    bus.imem_resp_valid = resp;
    bus.imem_resp_data  = drv_resp_data;
    bus.redirect_valid  = drv_redirect;
    bus.redirect_pc     = drv_redirect_pc;
    bus.inst_ready      = drv_inst_ready;
    if (!drv_rst) model_clear();

    @(negedge clk);
    e_addr  = {pc_reg[63:2], 2'b00};
    e_req   = drv_rst && (pend == 0) && (mq_pc.size() < DEPTH) && !drv_redirect;
    hs      = e_req && drv_ready;
    e_next  = drv_redirect ? drv_redirect_pc : (hs ? pc_reg + 64'd4 : pc_reg);
    e_valid = (mq_pc.size() != 0);

    chk("cmp next_pc", bus.next_pc, e_next);
    chk("cmp imem_req_valid", {63'd0, bus.imem_req_valid}, {63'd0, e_req});
    chk("cmp imem_addr", bus.imem_addr, e_addr);
    chk("cmp inst_valid", {63'd0, bus.inst_valid}, {63'd0, e_valid});
    if (e_valid) begin
      chk("cmp inst_data", {32'd0, bus.inst_data}, {32'd0, mq_data[0]});
      chk("cmp inst_pc", bus.inst_pc, mq_pc[0]);
    end else if (m_fresh) begin
      chk("cmp inst_data zero", {32'd0, bus.inst_data}, 64'd0);
      chk("cmp inst_pc zero", bus.inst_pc, 64'd0);
    end

    if (drv_rst) begin
      if (e_valid && drv_inst_ready) begin
        void'(mq_pc.pop_front());
        void'(mq_data.pop_front());
      end
      if (resp) begin
        if (pend == 1 && !drv_redirect) begin
          mq_pc.push_back(m_req_pc);
          mq_data.push_back(drv_resp_data);
          m_fresh = 1'b0;
        end
        pend = 0;
      end
      if (drv_redirect) begin
        mq_pc.delete();
        mq_data.delete();
        if (pend == 1) pend = 2;
      end
      if (hs) begin
        pend     = 1;
        m_req_pc = e_addr;
        resp_cd  = $urandom_range(lat_min, lat_max);
      end
    end
    pc_reg = e_next;
  endtask

  task automatic do_reset();
    drv_rst      = 1'b0;
    drv_redirect = 1'b0;
    tick();
    drv_rst      = 1'b1;
  endtask

  initial begin
    rand_mode       = 1'b0;
    drv_rst         = 1'b0;
    drv_redirect    = 1'b0;
    drv_redirect_pc = '0;
    drv_ready       = 1'b1;
    drv_inst_ready  = 1'b0;
    drv_resp_data   = 32'h0000_0013;
    lat_min         = 2;
    lat_max         = 2;
    pc_reg          = 64'h1234;
    resp_cd         = 0;
    rst                 = 1'b0;
    bus.pc_in           = '0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.inst_ready      = 1'b0;
    model_clear();

    // Reset state
    tick();
    tick();
    chk("reset inst_valid", {63'd0, bus.inst_valid}, 64'd0);
    chk("reset inst_data", {32'd0, bus.inst_data}, 64'd0);
    chk("reset inst_pc", bus.inst_pc, 64'd0);
    chk("reset imem_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
    chk("reset next_pc hold", bus.next_pc, 64'h1234);

    // 1: first fetch, 2-cycle memory
    pc_reg  = 64'h0;
    drv_rst = 1'b1;
    tick();
    chk("t1 next_pc", bus.next_pc, 64'h4);
    chk("t1 req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
    chk("t1 imem_addr", bus.imem_addr, 64'h0);
    tick();
    tick();
    chk("t1 inst_valid on resp", {63'd0, bus.inst_valid}, 64'd0);
    tick();
    chk("t1 inst_valid", {63'd0, bus.inst_valid}, 64'd1);
    chk("t1 inst_pc", bus.inst_pc, 64'h0);
    chk("t1 inst_data", {32'd0, bus.inst_data}, 64'h13);

    // 2: buffer fills to DEPTH with decode stalled
    do_reset();
    pc_reg = 64'h100; lat_min = 1; lat_max = 1; drv_inst_ready = 1'b0;
    drv_resp_data = 32'h0000_0093;
    repeat (8) tick();
    chk("t2 inst_valid", {63'd0, bus.inst_valid}, 64'd1);
    chk("t2 head pc", bus.inst_pc, 64'h100);
    chk("t2 req held", {63'd0, bus.imem_req_valid}, 64'd0);
    chk("t2 next_pc", bus.next_pc, 64'h108);
    chk("t2 pc_in", bus.pc_in, 64'h108);
    drv_inst_ready = 1'b1;
    tick();
    chk("t2 pop0 pc", bus.inst_pc, 64'h100);
    tick();
    chk("t2 pop1 pc", bus.inst_pc, 64'h104);
    tick();
    chk("t2 drained", {63'd0, bus.inst_valid}, 64'd0);

    // 3: redirect while waiting for a response
    do_reset();
    pc_reg = 64'h200; lat_min = 1; lat_max = 1; drv_inst_ready = 1'b0;
    tick();
    tick();
    lat_min = 3; lat_max = 3;
    tick();
    chk("t3 buffered", {63'd0, bus.inst_valid}, 64'd1);
    drv_redirect = 1'b1; drv_redirect_pc = 64'hAAAAAAAABBBBBBB8;
    tick();
    chk("t3 next_pc", bus.next_pc, 64'hAAAAAAAABBBBBBB8);
    chk("t3 no req", {63'd0, bus.imem_req_valid}, 64'd0);
    drv_redirect = 1'b0;
    tick();
    chk("t3 flushed", {63'd0, bus.inst_valid}, 64'd0);
    chk("t3 drop no req", {63'd0, bus.imem_req_valid}, 64'd0);
    tick();
    chk("t3 dropped resp", {63'd0, bus.inst_valid}, 64'd0);
    lat_min = 1; lat_max = 1;
    tick();
    chk("t3 req valid", {63'd0, bus.imem_req_valid}, 64'd1);
    chk("t3 req addr", bus.imem_addr, 64'hAAAAAAAABBBBBBB8);
    tick();
    tick();
    chk("t3 new inst_pc", bus.inst_pc, 64'hAAAAAAAABBBBBBB8);

    // 4: redirect coincides with the response
    do_reset();
    pc_reg = 64'h300; lat_min = 2; lat_max = 2; drv_inst_ready = 1'b0;
    tick();
    tick();
    drv_redirect = 1'b1; drv_redirect_pc = 64'h5000;
    tick();
    chk("t4 no req", {63'd0, bus.imem_req_valid}, 64'd0);
    chk("t4 next_pc", bus.next_pc, 64'h5000);
    drv_redirect = 1'b0;
    tick();
    chk("t4 req valid", {63'd0, bus.imem_req_valid}, 64'd1);
    chk("t4 req addr", bus.imem_addr, 64'h5000);
    chk("t4 discarded", {63'd0, bus.inst_valid}, 64'd0);

    // 5: PC wrap and address alignment
    do_reset();
    pc_reg = 64'hFFFFFFFFFFFFFFFC;
    tick();
    chk("t5 wrap next_pc", bus.next_pc, 64'h0);
    chk("t5 wrap addr", bus.imem_addr, 64'hFFFFFFFFFFFFFFFC);
    do_reset();
    pc_reg = 64'hAAAAAAAAFFFFFFFF;
    tick();
    chk("t5 align addr", bus.imem_addr, 64'hAAAAAAAAFFFFFFFC);
    chk("t5 align next_pc", bus.next_pc, 64'hAAAAAAAB00000003);

    // 6: reset while waiting; the late response must be ignored
    do_reset();
    pc_reg = 64'h400; lat_min = 3; lat_max = 3; drv_ready = 1'b1;
    tick();
    tick();
    drv_rst = 1'b0;
    tick();
    chk("t6 in reset", {63'd0, bus.inst_valid}, 64'd0);
    drv_rst = 1'b1; drv_ready = 1'b0;
    tick();
    tick();
    chk("t6 late resp ignored", {63'd0, bus.inst_valid}, 64'd0);
    chk("t6 req offered", {63'd0, bus.imem_req_valid}, 64'd1);
    tick();
    chk("t6 still empty", {63'd0, bus.inst_valid}, 64'd0);

    // Randomized traffic
    rand_mode = 1'b1;
    lat_min   = 1;
    lat_max   = 4;
    repeat (4000) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
